// File: rtl/md_issue_pkg.sv
// Shared encodings for the M-extension issue controller: funct3 values,
// controller states and the default WAIT timeout.
package md_issue_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam int TIMEOUT_DEFAULT = 48;

  localparam logic [31:0] WORD_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] WORD_ALL_ONES = 32'hFFFF_FFFF;

  // The divider handles every op with funct3[2] set; the multiplier the rest.
  function automatic logic is_div_family(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/md_special.sv
// Detects divide-by-zero and signed-overflow ops, which complete without the
// coprocessor, and supplies their architecturally defined result.
module md_special
  import md_issue_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        hit_o,
  output logic [31:0] result_o
);

  logic b_zero_s;
  logic ovf_s;

  assign b_zero_s = (b_i == 32'd0);
  assign ovf_s    = (a_i == WORD_INT_MIN) && (b_i == WORD_ALL_ONES);

  // Bypass decision and result per funct3
  always_comb begin
    hit_o    = 1'b0;
    result_o = 32'd0;
    case (f3_i)
      F3_DIV: begin
        if (b_zero_s) begin
          hit_o    = 1'b1;
          result_o = WORD_ALL_ONES;
        end else if (ovf_s) begin
          hit_o    = 1'b1;
          result_o = WORD_INT_MIN;
        end else begin
          hit_o    = 1'b0;
        end
      end
      F3_DIVU: begin
        if (b_zero_s) begin
          hit_o    = 1'b1;
          result_o = WORD_ALL_ONES;
        end else begin
          hit_o    = 1'b0;
        end
      end
      F3_REM: begin
        if (b_zero_s) begin
          hit_o    = 1'b1;
          result_o = a_i;
        end else if (ovf_s) begin
          hit_o    = 1'b1;
          result_o = 32'd0;
        end else begin
          hit_o    = 1'b0;
        end
      end
      F3_REMU: begin
        if (b_zero_s) begin
          hit_o    = 1'b1;
          result_o = a_i;
        end else begin
          hit_o    = 1'b0;
        end
      end
      F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU: begin
        hit_o = 1'b0;
      end
      default: begin
        hit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_issue.sv
// Issue controller for M-extension ops: hands operands to the shared mul/div
// coprocessor, waits out divider stalls and produces a one-cycle writeback.
module md_issue
  import md_issue_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_f3,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic [31:0] cop_a,
  output logic [31:0] cop_b,
  output logic [2:0]  cop_f3,
  output logic        cop_sel,
  input  logic [31:0] cop_ans,
  input  logic        cop_stall,
  input  logic        cop_ok,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic [4:0]  busy_rd,
  output logic        err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              accept_s;
  logic              spec_hit_s;
  logic [31:0]       spec_res_s;

  md_special u_special (
    .f3_i     (req_f3),
    .a_i      (req_a),
    .b_i      (req_b),
    .hit_o    (spec_hit_s),
    .result_o (spec_res_s)
  );

  // A flush in IDLE blocks acceptance for that cycle
  assign accept_s = req_valid && (state_q == ST_IDLE) && !flush;

  // Next-state, operand capture and WAIT timeout
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          f3_d = req_f3;
          rd_d = req_rd;
          a_d  = req_a;
          b_d  = req_b;
          if (spec_hit_s) begin
            res_d   = spec_res_s;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!is_div_family(f3_q)) begin
          res_d   = cop_ans;
          state_d = ST_DONE;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // flush beats a same-cycle result; a result beats the timeout
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (!cop_stall) begin
          res_d   = cop_ans;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (cop_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      f3_q    <= 3'd0;
      rd_q    <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign cop_sel   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign cop_a     = a_q;
  assign cop_b     = b_q;
  assign cop_f3    = f3_q;
  assign wb_valid  = (state_q == ST_DONE) && (rd_q != 5'd0) && !flush;
  assign wb_rd     = rd_q;
  assign wb_data   = res_q;
  assign busy      = (state_q != ST_IDLE);
  assign busy_rd   = busy ? rd_q : 5'd0;
  assign err       = err_q;

endmodule

// File: tb/tb_md_issue.sv
// Bench for md_issue: directed and random M-extension ops against an
// arithmetic reference and an event-timeline model of the controller.
module tb_md_issue;

  localparam int TMO = 48;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_f3;
  logic [4:0]  req_rd;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        flush;
  logic [31:0] cop_a;
  logic [31:0] cop_b;
  logic [2:0]  cop_f3;
  logic        cop_sel;
  logic [31:0] cop_ans;
  logic        cop_stall;
  logic        cop_ok;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [4:0]  busy_rd;
  logic        err;

  int    vectors;
  int    miscompares;
  string cur_tag;

  md_issue dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_f3    (req_f3),
    .req_rd    (req_rd),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .cop_a     (cop_a),
    .cop_b     (cop_b),
    .cop_f3    (cop_f3),
    .cop_sel   (cop_sel),
    .cop_ans   (cop_ans),
    .cop_stall (cop_stall),
    .cop_ok    (cop_ok),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .busy      (busy),
    .busy_rd   (busy_rd),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V M semantics by plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint     sa;
    longint     sb;
    longint     ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (f3)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin p = 64'(sa / sb); r = (b == 32'd0) ? 32'hFFFF_FFFF : p[31:0]; end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin p = 64'(sa % sb); r = (b == 32'd0) ? a : p[31:0]; end
      3'd7: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic bit is_bypass(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Coprocessor stand-in: garbage while stalled or for ops it must never see
  always_comb begin
    if (cop_stall) cop_ans = 32'hBAD0_BAD0;
    else if (is_bypass(cop_f3, cop_a, cop_b)) cop_ans = 32'hDEAD_BEEF;
    else cop_ans = ref_md(cop_f3, cop_a, cop_b);
  end

  task automatic chk(input string name, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s cyc %0d: observed %0h expected %0h", cur_tag, name, cyc, obs, exp);
    end
  endtask

  // One op; fl = cycle of a flush pulse (-1 none), okl = cycles cop_ok stays low in DRAIN
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d,
                        input int stall, input int fl, input int okl);
    bit spec;
    int sel_hi, done_c, err_c, drain_lo, end_c;
    bit e_busy, e_sel, e_wb;
    cur_tag  = tag;
    spec     = is_bypass(f3, a, b);
    sel_hi   = 0;
    done_c   = -1;
    err_c    = -1;
    drain_lo = -1;
    end_c    = -1;
    if (spec) done_c = 1;
    else if (!f3[2]) begin sel_hi = 1; done_c = 2; end
    else if (stall >= TMO) begin sel_hi = 1 + TMO; err_c = 2 + TMO; drain_lo = 2 + TMO; end
    else begin sel_hi = stall + 2; done_c = stall + 3; end
    if (fl >= 0 && fl != done_c) begin
      if (fl == 1) begin sel_hi = 1; done_c = -1; end_c = 2; end
      else begin sel_hi = fl; done_c = -1; err_c = -1; drain_lo = fl + 1; end
    end
    if (end_c < 0) end_c = (drain_lo >= 0) ? drain_lo + okl + 1 : done_c + 1;
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      req_valid = (c == 0);
      req_f3    = (c == 0) ? f3 : 3'($urandom_range(0, 7));
      req_rd    = (c == 0) ? rd : 5'($urandom);
      req_a     = (c == 0) ? a : 32'($urandom);
      req_b     = (c == 0) ? b : 32'($urandom);
      flush     = (c == fl);
      cop_stall = f3[2] && (c >= 1) && (c <= stall + 1);
      cop_ok    = !(drain_lo >= 0 && c >= drain_lo && c < drain_lo + okl);
      #1;
      e_busy = (c >= 1) && (c < end_c);
      e_sel  = (c >= 1) && (c <= sel_hi);
      e_wb   = (c == done_c) && (rd != 5'd0) && (c != fl);
      chk("busy", c, 32'(busy), 32'(e_busy));
      chk("busy_rd", c, 32'(busy_rd), e_busy ? 32'(rd) : 32'd0);
      chk("req_ready", c, 32'(req_ready), 32'(!e_busy));
      chk("cop_sel", c, 32'(cop_sel), 32'(e_sel));
      chk("wb_valid", c, 32'(wb_valid), 32'(e_wb));
      chk("err", c, 32'(err), 32'(c == err_c));
      if (e_sel) begin
        chk("cop_a", c, cop_a, a);
        chk("cop_b", c, cop_b, b);
        chk("cop_f3", c, 32'(cop_f3), 32'(f3));
      end
      if (e_wb) begin
        chk("wb_rd", c, 32'(wb_rd), 32'(rd));
        chk("wb_data", c, wb_data, exp_d);
      end
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    cop_stall = 1'b0;
    cop_ok    = 1'b1;
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [4:0]  rrd;
    logic [31:0] ra, rb;
    int          sel;
    vectors     = 0;
    miscompares = 0;
    cur_tag     = "reset";
    rst = 1'b1; req_valid = 1'b0; req_f3 = 3'd0; req_rd = 5'd0; req_a = 32'd0; req_b = 32'd0;
    flush = 1'b0; cop_stall = 1'b0; cop_ok = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("busy", 0, 32'(busy), 32'd0);
    chk("busy_rd", 0, 32'(busy_rd), 32'd0);
    chk("wb_valid", 0, 32'(wb_valid), 32'd0);
    chk("wb_data", 0, wb_data, 32'd0);
    chk("cop_sel", 0, 32'(cop_sel), 32'd0);
    chk("err", 0, 32'(err), 32'd0);
    rst = 1'b0;

    run_op("mul_neg",   3'd0, 5'd5, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, -1, 0);
    run_op("div_100_7", 3'd4, 5'd3, 32'd100, 32'd7, 32'd14, 33, -1, 0);
    run_op("rem_100_7", 3'd6, 5'd3, 32'd100, 32'd7, 32'd2, 33, -1, 0);
    run_op("divu_by0",  3'd5, 5'd9, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, -1, 0);
    run_op("remu_by0",  3'd7, 5'd9, 32'd5, 32'd0, 32'd5, 0, -1, 0);
    run_op("div_ovf",   3'd4, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, -1, 0);
    run_op("rem_ovf",   3'd6, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, -1, 0);
    run_op("flush_wait", 3'd4, 5'd6, 32'd1000, 32'd3, 32'd333, 40, 11, 20);
    run_op("flush_vs_done", 3'd5, 5'd6, 32'd1000, 32'd3, 32'd333, 5, 7, 3);
    run_op("timeout",   3'd5, 5'd7, 32'd77, 32'd5, 32'd15, 100, -1, 0);
    run_op("timeout_drain", 3'd6, 5'd8, 32'd77, 32'd5, 32'd2, 100, -1, 4);
    run_op("mul_rd0",   3'd0, 5'd0, 32'd3, 32'd4, 32'd12, 0, -1, 0);
    run_op("flush_issue", 3'd1, 5'd2, 32'd3, 32'd4, 32'd0, 0, 1, 0);
    run_op("flush_done", 3'd0, 5'd2, 32'd3, 32'd4, 32'd12, 0, 2, 0);

    cur_tag = "flush_idle";
    @(negedge clk);
    req_valid = 1'b1; req_f3 = 3'd0; req_rd = 5'd1; req_a = 32'd2; req_b = 32'd2; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("busy", 1, 32'(busy), 32'd0);
    chk("cop_sel", 1, 32'(cop_sel), 32'd0);

    cur_tag = "rst_wait";
    @(negedge clk);
    req_valid = 1'b1; req_f3 = 3'd4; req_rd = 5'd11; req_a = 32'd50; req_b = 32'd6; cop_stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("cop_sel", 5, 32'(cop_sel), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cop_stall = 1'b0;
    #1;
    chk("busy", 6, 32'(busy), 32'd0);
    chk("busy_rd", 6, 32'(busy_rd), 32'd0);
    chk("cop_sel", 6, 32'(cop_sel), 32'd0);
    chk("wb_data", 6, wb_data, 32'd0);
    @(negedge clk);
    #1;
    chk("wb_valid", 7, 32'(wb_valid), 32'd0);
    chk("err", 7, 32'(err), 32'd0);

    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      rrd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      ra  = 32'($urandom);
      rb  = 32'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (sel == 2) rb = 32'($urandom_range(1, 9));
      run_op("random", rf3, rrd, ra, rb, ref_md(rf3, ra, rb), $urandom_range(0, 10), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
